// File: rtl/codes.sv
// Shared encodings for the core/bus interface: access sizes, bus FSM states and
// the alignment rule used when a request is accepted.
package codes;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } bus_state_t;

  function automatic logic is_misaligned(mem_size_t size, logic [2:0] addr_lo);
    logic r;
    case (size)
      SZ_BYTE:  r = 1'b0;
      SZ_HALF:  r = addr_lo[0];
      SZ_WORD:  r = |addr_lo[1:0];
      default:  r = |addr_lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data for an
// access, plus extraction and sign/zero extension of load data.
module bus_lane_align
  import codes::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int NBYTES = DATA_WIDTH / 8,
  localparam int OFF_W  = $clog2(NBYTES)
) (
  input  mem_size_t              i_size,
  input  logic [OFF_W-1:0]       i_off,
  input  logic                   i_signed,
  input  logic [DATA_WIDTH-1:0]  i_wdata,
  input  logic [DATA_WIDTH-1:0]  i_rdata,
  output logic [NBYTES-1:0]      o_byteenable,
  output logic [DATA_WIDTH-1:0]  o_writedata,
  output logic [DATA_WIDTH-1:0]  o_rdata
);

  logic [OFF_W+2:0]      w_shamt;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_msb;

  always_comb begin
    w_shamt   = {i_off, 3'b000};
    w_shifted = i_rdata >> w_shamt;
    case (i_size)
      SZ_BYTE: begin
        o_byteenable = NBYTES'(1) << i_off;
        o_writedata  = {NBYTES{i_wdata[7:0]}};
        w_mask       = DATA_WIDTH'(8'hFF);
        w_msb        = w_shifted[7];
      end
      SZ_HALF: begin
        o_byteenable = NBYTES'(3) << i_off;
        o_writedata  = {(NBYTES / 2){i_wdata[15:0]}};
        w_mask       = DATA_WIDTH'(16'hFFFF);
        w_msb        = w_shifted[15];
      end
      SZ_WORD: begin
        o_byteenable = NBYTES'(15) << i_off;
        o_writedata  = {(NBYTES / 4){i_wdata[31:0]}};
        w_mask       = DATA_WIDTH'(32'hFFFF_FFFF);
        w_msb        = w_shifted[31];
      end
      default: begin
        o_byteenable = '1;
        o_writedata  = i_wdata;
        w_mask       = '1;
        w_msb        = w_shifted[DATA_WIDTH-1];
      end
    endcase
    // Bits above the access size are filled with the sign bit or zero.
    o_rdata = (w_shifted & w_mask) | ({DATA_WIDTH{i_signed & w_msb}} & ~w_mask);
  end

endmodule

// File: rtl/bus_mem_unit.sv
// Avalon-MM master access unit: registers one core request, holds the bus under
// waitrequest, and returns a one-cycle done/err pulse with extended load data.
module bus_mem_unit
  import codes::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int NBYTES = DATA_WIDTH / 8,
  localparam int OFF_W  = $clog2(NBYTES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_i,
  input  logic                   we_i,
  input  mem_size_t              size_i,
  input  logic                   signed_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  output logic                   stall_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [DATA_WIDTH-1:0]  rdata_o,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   read,
  output logic                   write,
  input  logic                   waitrequest,
  output logic [DATA_WIDTH-1:0]  writedata,
  output logic [NBYTES-1:0]      byteenable,
  input  logic [DATA_WIDTH-1:0]  readdata
);

  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

  bus_state_t            r_state;
  logic                  r_we;
  mem_size_t             r_size;
  logic                  r_signed;
  logic [OFF_W-1:0]      r_off;
  logic [31:0]           r_wait_cnt;
  logic                  r_done;
  logic                  r_err;
  logic                  r_read;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_writedata;
  logic [NBYTES-1:0]     r_byteenable;

  logic                  w_idle;
  mem_size_t             w_size;
  logic [OFF_W-1:0]      w_off;
  logic                  w_signed;
  logic [NBYTES-1:0]     w_be;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_rd;
  logic                  w_misaligned;
  logic [31:0]           w_cnt_next;

  // Idle: steer the incoming request; during the access: the captured one.
  assign w_idle       = (r_state == S_IDLE);
  assign w_size       = w_idle ? size_i : r_size;
  assign w_off        = w_idle ? addr_i[OFF_W-1:0] : r_off;
  assign w_signed     = w_idle ? signed_i : r_signed;
  assign w_misaligned = is_misaligned(size_i, addr_i[2:0]);
  assign w_cnt_next   = r_wait_cnt + 32'd1;

  bus_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_size       (w_size),
    .i_off        (w_off),
    .i_signed     (w_signed),
    .i_wdata      (wdata_i),
    .i_rdata      (readdata),
    .o_byteenable (w_be),
    .o_writedata  (w_wd),
    .o_rdata      (w_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_off        <= '0;
      r_wait_cnt   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_rdata      <= '0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_byteenable <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we         <= we_i;
            r_size       <= size_i;
            r_signed     <= signed_i;
            r_off        <= addr_i[OFF_W-1:0];
            r_address    <= {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            r_writedata  <= w_wd;
            r_byteenable <= w_be;
            r_wait_cnt   <= '0;
            if (w_misaligned) begin
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
              r_read  <= ~we_i;
              r_write <= we_i;
            end
          end
        end
        S_ACCESS: begin
          if (!waitrequest) begin
            if (!r_we) r_rdata <= w_rd;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_state <= S_RESP;
            r_done  <= 1'b1;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if ((TIMEOUT != 32'd0) && (w_cnt_next == TIMEOUT)) begin
              r_read  <= 1'b0;
              r_write <= 1'b0;
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o    = (w_idle & req_i) | (r_state == S_ACCESS);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign rdata_o    = r_rdata;
  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;

endmodule

// File: tb/tb_bus_mem_unit.sv
// Bench for bus_mem_unit: a 32-bit instance with an 8-cycle timeout and a 64-bit
// instance without timeout, driven by a vector table, hand sequences and random traffic.
module tb_bus_mem_unit;
  import codes::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req32, req64, we, sgn, waitreq;
  mem_size_t   size;
  logic [31:0] addr;
  logic [63:0] wdata, rdbus;

  logic        stall32, done32, err32, read32, write32;
  logic [31:0] rdata32, address32, wd32;
  logic [3:0]  be32;
  logic        stall64, done64, err64, read64, write64;
  logic [63:0] rdata64, wd64;
  logic [31:0] address64;
  logic [7:0]  be64;

  int total = 0;
  int bad   = 0;

  bus_mem_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) u32 (
    .clk(clk), .reset(reset), .req_i(req32), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata[31:0]), .stall_o(stall32), .done_o(done32), .err_o(err32),
    .rdata_o(rdata32), .address(address32), .read(read32), .write(write32),
    .waitrequest(waitreq), .writedata(wd32), .byteenable(be32), .readdata(rdbus[31:0])
  );

  bus_mem_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) u64 (
    .clk(clk), .reset(reset), .req_i(req64), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall64), .done_o(done64), .err_o(err64),
    .rdata_o(rdata64), .address(address64), .read(read64), .write(write64),
    .waitrequest(waitreq), .writedata(wd64), .byteenable(be64), .readdata(rdbus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: byte-by-byte view of one access.
  function automatic void model(input int nb, input int sz, input bit s, input logic [31:0] a,
                                input logic [63:0] wd_in, input logic [63:0] rd_in,
                                output logic [63:0] be, output logic [63:0] wd,
                                output logic [63:0] ld, output bit err);
    int n   = 1 << sz;
    int off = int'(a % nb);
    err = (a % n) != 0;
    be = '0;
    for (int i = 0; i < n; i++) be[off+i] = 1'b1;
    wd = '0;
    for (int j = 0; j < nb; j++) wd[8*j +: 8] = wd_in[8*(j % n) +: 8];
    ld = '0;
    for (int i = 0; i < n; i++) if (off + i < nb) ld[8*i +: 8] = rd_in[8*(off+i) +: 8];
    if (s && ld[8*n-1]) for (int i = n; i < nb; i++) ld[8*i +: 8] = 8'hFF;
  endfunction

  task automatic run_access(input bit sel, input bit a_we, input logic [1:0] a_size,
                            input bit a_sgn, input logic [31:0] a_addr,
                            input logic [63:0] a_wdata, input logic [63:0] a_rd, input int waits,
                            output logic [63:0] o_be, output logic [63:0] o_address,
                            output logic [63:0] o_wd, output logic [63:0] o_rdata,
                            output bit o_err, output int o_lat, output int o_strobes,
                            output bit o_ok);
    bit          done_seen;
    logic [63:0] cbe, cad, cwd;
    logic        crd, cwr;
    @(negedge clk);
    we = a_we; size = mem_size_t'(a_size); sgn = a_sgn; addr = a_addr;
    wdata = a_wdata; rdbus = a_rd; waitreq = 1'b0;
    if (sel) req64 = 1'b1; else req32 = 1'b1;
    #1;
    o_ok = ((sel ? stall64 : stall32) === 1'b1);
    o_lat = -1; o_strobes = 0; o_err = 1'b0; done_seen = 1'b0;
    o_be = '0; o_address = '0; o_wd = '0; o_rdata = '0;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      req32 = 1'b0; req64 = 1'b0;
      // Scramble request inputs: the unit must ignore them once busy.
      we = 1'($urandom); sgn = 1'($urandom); addr = $urandom;
      wdata = {$urandom, $urandom}; size = mem_size_t'($urandom_range(0, 3));
      crd = sel ? read64 : read32;
      cwr = sel ? write64 : write32;
      cbe = sel ? 64'(be64) : 64'(be32);
      cad = sel ? 64'(address64) : 64'(address32);
      cwd = sel ? wd64 : 64'(wd32);
      if (crd | cwr) begin
        o_strobes++;
        if (o_strobes == 1) begin
          o_be = cbe; o_address = cad; o_wd = cwd;
        end else if (cbe !== o_be || cad !== o_address || cwd !== o_wd) begin
          o_ok = 1'b0;
        end
        if (crd !== ~a_we || cwr !== a_we) o_ok = 1'b0;
        if ((sel ? stall64 : stall32) !== 1'b1) o_ok = 1'b0;
        waitreq = (o_strobes <= waits);
      end else begin
        waitreq = 1'b0;
      end
      if (sel ? done64 : done32) begin
        o_lat = c;
        o_err = sel ? err64 : err32;
        o_rdata = sel ? rdata64 : 64'(rdata32);
        if ((sel ? stall64 : stall32) !== 1'b0) o_ok = 1'b0;
        done_seen = 1'b1;
      end
    end
    @(negedge clk);
    if ((sel ? done64 : done32) !== 1'b0) o_ok = 1'b0;
  endtask

  typedef struct {
    bit          sel;
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd;
    int          waits;
    logic [63:0] e_be;
    logic [63:0] e_address;
    logic [63:0] e_wd;
    logic [63:0] e_rdata;
    bit          e_err;
    int          e_lat;
    int          e_strobes;
  } vec_t;

  vec_t        tbl[14];
  logic [63:0] o_be, o_address, o_wd, o_rdata, m_be, m_wd, m_ld;
  logic [63:0] last_rd[2];
  bit          o_err, o_ok, m_err, rsel, rwe, rsgn;
  int          o_lat, o_strobes, rsz, rwaits, nb;
  logic [31:0] raddr;
  logic [63:0] rwd, rrd;

  initial begin
    reset = 1'b0; req32 = 1'b0; req64 = 1'b0; we = 1'b0; sgn = 1'b0; waitreq = 1'b0;
    size = SZ_BYTE; addr = '0; wdata = '0; rdbus = '0;

    //                sel we size sgn addr      wdata                  rd                     w  be     address  wd                     rdata                  e  lat str
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h1003, 64'h0,                 64'h80AB_CD12,         0, 64'h8,  64'h1000, 64'h0,               64'h80,                0, 2, 1};
    tbl[1]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h2002, 64'h0,                 64'h8001_7777,         0, 64'hC,  64'h2000, 64'h0,               64'hFFFF_8001,         0, 2, 1};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h3001, 64'h5A,                64'h0,                 3, 64'h2,  64'h3000, 64'h5A5A_5A5A,       64'hFFFF_8001,         0, 5, 4};
    tbl[3]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h4002, 64'h0,                 64'hFFFF_FFFF,         0, 64'h0,  64'h0,    64'h0,               64'hFFFF_8001,         1, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h5000, 64'h0,                 64'h1234_5678,        99, 64'hF,  64'h5000, 64'h0,               64'hFFFF_8001,         1, 9, 8};
    tbl[5]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h6002, 64'h0,                 64'h8001_7777,         0, 64'hC,  64'h6000, 64'h0,               64'h8001,              0, 2, 1};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h7002, 64'h1234_ABCD,         64'h0,                 0, 64'hC,  64'h7000, 64'hABCD_ABCD,       64'h8001,              0, 2, 1};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h0000, 64'h0,                 64'h0000_00F0,         0, 64'h1,  64'h0,    64'h0,               64'hFFFF_FFF0,         0, 2, 1};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0008, 64'hDEAD_BEEF,         64'h0,                 1, 64'hF,  64'h8,    64'hDEAD_BEEF,       64'hFFFF_FFF0,         0, 3, 2};
    tbl[9]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h0001, 64'h0,                 64'hFFFF_FFFF,         0, 64'h0,  64'h0,    64'h0,               64'hFFFF_FFF0,         1, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0008, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 64'hFF, 64'h8,  64'h0,               64'h0123_4567_89AB_CDEF, 0, 2, 1};
    tbl[11] = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h0004, 64'h0,                 64'h8000_0000_0000_0000, 0, 64'hF0, 64'h0,  64'h0,               64'hFFFF_FFFF_8000_0000, 0, 2, 1};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0007, 64'h11,                64'h0,                 2, 64'h80, 64'h0,    64'h1111_1111_1111_1111, 64'hFFFF_FFFF_8000_0000, 0, 4, 3};
    tbl[13] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0004, 64'h0,                 64'hFFFF,              0, 64'h0,  64'h0,    64'h0,               64'hFFFF_FFFF_8000_0000, 1, 1, 0};

    #2;
    chk("rst_read", 64'(read32), 64'h0);
    chk("rst_write", 64'(write32), 64'h0);
    chk("rst_done", 64'(done32), 64'h0);
    chk("rst_err", 64'(err32), 64'h0);
    chk("rst_address", 64'(address32), 64'h0);
    chk("rst_writedata", 64'(wd32), 64'h0);
    chk("rst_rdata", 64'(rdata32), 64'h0);
    chk("rst_be", 64'(be32), 64'h0);
    chk("rst_be64", 64'(be64), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_access(tbl[i].sel, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                 tbl[i].rd, tbl[i].waits, o_be, o_address, o_wd, o_rdata, o_err, o_lat,
                 o_strobes, o_ok);
      chk($sformatf("v%0d_lat", i), 64'(o_lat), 64'(tbl[i].e_lat));
      chk($sformatf("v%0d_strobes", i), 64'(o_strobes), 64'(tbl[i].e_strobes));
      chk($sformatf("v%0d_err", i), 64'(o_err), 64'(tbl[i].e_err));
      chk($sformatf("v%0d_rdata", i), o_rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_protocol", i), 64'(o_ok), 64'h1);
      if (tbl[i].e_strobes > 0) begin
        chk($sformatf("v%0d_be", i), o_be, tbl[i].e_be);
        chk($sformatf("v%0d_address", i), o_address, tbl[i].e_address);
        if (tbl[i].we) chk($sformatf("v%0d_writedata", i), o_wd, tbl[i].e_wd);
      end
    end

    // Reset pulled in the middle of a stalled read.
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; sgn = 1'b0; addr = 32'h9000; req32 = 1'b1; waitreq = 1'b1;
    @(negedge clk);
    req32 = 1'b0;
    chk("midrst_read_before", 64'(read32), 64'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_read_drop", 64'(read32), 64'h0);
    chk("midrst_address", 64'(address32), 64'h0);
    chk("midrst_stall", 64'(stall32), 64'h0);
    @(negedge clk);
    reset = 1'b1; waitreq = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done32), 64'h0);
      chk("midrst_no_read", 64'(read32), 64'h0);
    end

    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int k = 0; k < 300; k++) begin
      rsel   = 1'($urandom);
      nb     = rsel ? 8 : 4;
      rsz    = int'($urandom_range(0, rsel ? 3 : 2));
      rwe    = 1'($urandom);
      rsgn   = 1'($urandom);
      raddr  = $urandom;
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~32'((1 << rsz) - 1);
      rwd    = {$urandom, $urandom};
      rrd    = {$urandom, $urandom};
      rwaits = int'($urandom_range(0, 3));
      model(nb, rsz, rsgn, raddr, rwd, rrd, m_be, m_wd, m_ld, m_err);
      if (!m_err && !rwe) last_rd[rsel] = m_ld;
      run_access(rsel, rwe, 2'(rsz), rsgn, raddr, rwd, rrd, rwaits, o_be, o_address, o_wd,
                 o_rdata, o_err, o_lat, o_strobes, o_ok);
      chk($sformatf("r%0d_err", k), 64'(o_err), 64'(m_err));
      chk($sformatf("r%0d_lat", k), 64'(o_lat), m_err ? 64'd1 : 64'(2 + rwaits));
      chk($sformatf("r%0d_rdata", k), o_rdata, last_rd[rsel]);
      chk($sformatf("r%0d_protocol", k), 64'(o_ok), 64'h1);
      if (!m_err) begin
        chk($sformatf("r%0d_strobes", k), 64'(o_strobes), 64'(1 + rwaits));
        chk($sformatf("r%0d_be", k), o_be, m_be);
        chk($sformatf("r%0d_address", k), o_address, 64'(raddr & ~32'(nb - 1)));
        if (rwe) chk($sformatf("r%0d_writedata", k), o_wd, m_wd);
      end else begin
        chk($sformatf("r%0d_nostrobe", k), 64'(o_strobes), 64'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mem_unit.md
# bus_mem_unit

Parametrised Avalon-MM master access unit between the multicycle core (control/FSM, IR, ALU) and the external memory bus. It replaces direct driving of `address`/`read`/`write` and the fixed `byteenable = 4'b1111`. It registers each fetch/load/store request and holds the bus stable under `waitrequest`, stalling the core meanwhile. It generates byte lanes for byte/half/word accesses, returns sign- or zero-extended load data, and reports misalignment and bus timeout.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bus data width; 32 or 64. `NBYTES = DATA_WIDTH/8`, `OFF_W = $clog2(NBYTES)`.
- `ADDR_WIDTH`, 32: byte address width.
- `TIMEOUT_CYCLES`, 0: maximum cycles `waitrequest` may stay high before abort. 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  core access request.
- `we_i`  in  1  1 = store, 0 = load/fetch.
- `size_i`  in  `mem_size_t`  SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD. SZ_DWORD is legal only when `DATA_WIDTH` = 64.
- `signed_i`  in  1  sign-extend load result.
- `addr_i`  in  ADDR_WIDTH  byte address.
- `wdata_i`  in  DATA_WIDTH  store data, right-justified.
- `stall_o`  out  1  core must hold its FSM.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  one-cycle pulse together with `done_o`: misaligned access or timeout.
- `rdata_o`  out  DATA_WIDTH  extended load data; holds until the next successful load.
- `address`  out  ADDR_WIDTH  bus address, with the low OFF_W bits forced to 0.
- `read`, `write`  out  1  Avalon strobes.
- `waitrequest`  in  1  Avalon slave stall.
- `writedata`  out  DATA_WIDTH  lane-replicated store data.
- `byteenable`  out  NBYTES  active byte lanes.
- `readdata`  in  DATA_WIDTH  bus read data.

## Operation
- FSM states (`bus_state_t`): S_IDLE, S_ACCESS, S_RESP.
- S_IDLE with `req_i`=1:
  - Capture we/size/signed/offset/address/data.
  - Aligned request → S_ACCESS.
  - Misaligned request → S_RESP with the error flag set. Misaligned means: half with `addr[0]`≠0; word with `addr[1:0]`≠0; dword with `addr[2:0]`≠0.
- S_ACCESS:
  - `read` = ~we; `write` = we. `address`, `writedata` and `byteenable` are registered and constant for the whole state.
  - `waitrequest`=0 at an edge: the transfer completes. For a load, `rdata_o` loads the extracted/extended `readdata`. Next state is S_RESP.
  - `waitrequest`=1: the wait counter increments. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), the transfer is aborted: S_RESP with the error flag set.
- S_RESP:
  - `done_o`=1, and `err_o` = error flag.
  - `rdata_o` is unchanged on an error.
  - Next state is always S_IDLE.
- Lane rules, with `off` = `addr[OFF_W-1:0]`:
  - byte: `byteenable` = 1<<off.
  - half: `byteenable` = 3<<off.
  - word: `byteenable` = 4'hF<<off.
  - dword: all ones.
  - `writedata` replicates the low byte/half/word across all lanes.
  - Load: `readdata`>>(8·off), masked to the access size, then sign-extended if `signed_i`, otherwise zero-extended.
- `stall_o` = (S_IDLE & `req_i`) | S_ACCESS. `stall_o` is 0 in S_RESP, so the core advances on the `done_o` cycle.
- Inputs are ignored outside S_IDLE. `req_i` asserted in S_RESP is not accepted until S_IDLE.

## Timing
- Reset values:
  - state S_IDLE.
  - `read`, `write`, `done_o`, `err_o` all 0.
  - `address`, `writedata`, `rdata_o` all 0.
  - `byteenable` 0, wait counter 0.
- Reset asserted mid-access drops `read`/`write` asynchronously. No `done_o` is produced for the interrupted access.
- Zero-wait access: request sampled at edge N; strobe high in cycle N..N+1; `done_o` and `rdata_o` valid in cycle N+1..N+2. That is 2 cycles, plus one cycle per waitrequest-high cycle.
- Misaligned access: `done_o`+`err_o` in cycle N..N+1, with no bus strobe.
- Timeout: the strobe is held for exactly TIMEOUT_CYCLES cycles, then `done_o`+`err_o`.
- `rdata_o` updates at the completion edge and is stable while `done_o`=1.

## Structure
- Package `codes` gains `mem_size_t` (2-bit) and `bus_state_t`.
- Sub-module `bus_lane_align` (combinational, parametrised by DATA_WIDTH) produces `byteenable`, replicated `writedata` and extended load data. It is shared with the future cache path.
- Top level holds the FSM, capture registers and wait counter. `mips_cpu_bus` instantiates the unit and drives `stall` from `stall_alu | stall_o`.

## Test plan
- LBU, DATA_WIDTH=32, addr 0x1003, `readdata` 0x80AB_CD12 → `byteenable` 4'b1000, `address` 0x1000, `rdata_o` 0x0000_0080, `done_o` at request+2.
- LH signed, addr 0x2002, `readdata` 0x8001_7777 → `byteenable` 4'b1100, `rdata_o` 0xFFFF_8001.
- SB, addr 0x3001, `wdata_i` 0x0000_005A, `waitrequest` high 3 cycles → `writedata` 0x5A5A_5A5A, `byteenable` 4'b0010; `write` held 4 cycles with `address`/`writedata` stable; `done_o` at request+5.
- LW, addr 0x4002 → no `read` strobe, `done_o`=`err_o`=1 next cycle, `rdata_o` unchanged.
- TIMEOUT_CYCLES=8, `waitrequest` stuck high → `read` high exactly 8 cycles, then `err_o`+`done_o`; `reset`=0 pulled during a second access → `read` falls immediately, state S_IDLE.
- DATA_WIDTH=64, LD at 0x8, `readdata` 0x0123_4567_89AB_CDEF → `byteenable` 8'hFF, `rdata_o` equals `readdata`.
